mem_wb_pipe_buf: RTL

//  Parametrised MEM->WB pipeline stage with valid/ready handshake, a 2-entry skid buffer,

---
 rtl/mem_wb_pipe_buf_pkg.sv | 26 ++
 rtl/mem_wb_pipe_buf_if.sv | 42 ++++
 rtl/mem_wb_pipe_buf_skid.sv | 88 ++++++++
 rtl/mem_wb_pipe_buf.sv | 49 ++++
 4 files changed

// File: rtl/mem_wb_pipe_buf_pkg.sv
// Shared types for the MEM->WB pipeline buffer: entry layout and occupancy encodings.
package mem_wb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Field order here matches the packed vector carried through skid_buf2.
    typedef struct packed {
        logic                      memtoreg;
        logic                      regwrite;
        logic [DATA_W_DEF-1:0]     data_in;
        logic [DATA_W_DEF-1:0]     alu;
        logic [REG_ADDR_W_DEF-1:0] reg_write;
    } mem_wb_entry_t;

    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    function automatic int entry_w(input int dw, input int aw);
        return 2 + 2 * dw + aw;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_buf_if.sv
// MEM-side and WB-side bus of the MEM->WB buffer; slave is the buffer, master the environment.
interface mem_wb_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_memtoreg;
    logic                  mem_regwrite;
    logic [DATA_W-1:0]     mem_data_in;
    logic [DATA_W-1:0]     mem_alu;
    logic [REG_ADDR_W-1:0] mem_reg_write;

    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_memtoreg;
    logic                  wb_regwrite;
    logic [DATA_W-1:0]     wb_data_out;
    logic [DATA_W-1:0]     wb_alu;
    logic [REG_ADDR_W-1:0] wb_reg_write;
    logic [DATA_W-1:0]     wb_result;

    logic                  fwd_en;
    logic [REG_ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0]     fwd_data;

    modport slave (
        input  mem_valid, mem_memtoreg, mem_regwrite, mem_data_in, mem_alu, mem_reg_write,
        input  wb_ready,
        output mem_ready,
        output wb_valid, wb_memtoreg, wb_regwrite, wb_data_out, wb_alu, wb_reg_write, wb_result,
        output fwd_en, fwd_addr, fwd_data
    );

    modport master (
        output mem_valid, mem_memtoreg, mem_regwrite, mem_data_in, mem_alu, mem_reg_write,
        output wb_ready,
        input  mem_ready,
        input  wb_valid, wb_memtoreg, wb_regwrite, wb_data_out, wb_alu, wb_reg_write, wb_result,
        input  fwd_en, fwd_addr, fwd_data
    );
endinterface

// File: rtl/mem_wb_pipe_buf_skid.sv
// Generic 2-entry valid/ready skid buffer; ready is registered so the upstream
// never sees a combinational path from downstream ready.
module skid_buf2
    import mem_wb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    cnt_e         r_cnt;
    cnt_e         w_nxt;
    logic         r_ready;
    logic [W-1:0] r_head;
    logic [W-1:0] r_skid;
    logic         w_accept;
    logic         w_pop;
    logic         w_ld_head;
    logic         w_ld_skid;
    logic         w_shift;

    assign o_valid  = (r_cnt != CNT_EMPTY);
    assign o_ready  = r_ready;
    assign o_data   = r_head;
    assign w_accept = i_valid & r_ready;
    assign w_pop    = o_valid & i_ready;

    always_comb begin
        w_nxt     = r_cnt;
        w_ld_head = 1'b0;
        w_ld_skid = 1'b0;
        w_shift   = 1'b0;
        case (r_cnt)
            CNT_EMPTY: if (w_accept) begin
                w_ld_head = 1'b1;
                w_nxt     = CNT_ONE;
            end
            CNT_ONE: begin
                if (w_accept && w_pop) begin
                    w_ld_head = 1'b1;
                end else if (w_accept) begin
                    w_ld_skid = 1'b1;
                    w_nxt     = CNT_FULL;
                end else if (w_pop) begin
                    w_nxt     = CNT_EMPTY;
                end
            end
            CNT_FULL: if (w_pop) begin
                w_shift = 1'b1;
                w_nxt   = CNT_ONE;
            end
            default: w_nxt = CNT_EMPTY;
        endcase
        // Flush wins over any same-cycle accept or pop; the incoming word is dropped.
        if (i_flush) begin
            w_nxt     = CNT_EMPTY;
            w_ld_head = 1'b0;
            w_ld_skid = 1'b0;
            w_shift   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= CNT_EMPTY;
            r_ready <= 1'b0;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_cnt   <= w_nxt;
            r_ready <= (w_nxt != CNT_FULL);
            if (w_ld_head)
                r_head <= i_data;
            else if (w_shift)
                r_head <= r_skid;
            if (w_ld_skid)
                r_skid <= i_data;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_buf.sv
// MEM->WB pipeline stage: skid-buffered valid/ready register with RegWrite gating,
// write-back result mux and a forwarding tap off the head entry.
module mem_wb_pipe_buf
    import mem_wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int ZERO_REG_WE = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    mem_wb_if.slave bus
);
    localparam int EW = entry_w(DATA_W, REG_ADDR_W);

    logic [EW-1:0] w_in;
    logic [EW-1:0] w_head;
    logic          w_head_rw;
    logic          w_dest_ok;

    assign w_in = {bus.mem_memtoreg, bus.mem_regwrite, bus.mem_data_in,
                   bus.mem_alu, bus.mem_reg_write};

    skid_buf2 #(.W(EW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (bus.mem_valid),
        .o_ready (bus.mem_ready),
        .i_data  (w_in),
        .o_valid (bus.wb_valid),
        .i_ready (bus.wb_ready),
        .o_data  (w_head)
    );

    assign {bus.wb_memtoreg, w_head_rw, bus.wb_data_out,
            bus.wb_alu, bus.wb_reg_write} = w_head;

    // Writes to r0 are dropped at the source so forwarding never advertises them either.
    assign w_dest_ok       = (ZERO_REG_WE != 0) || (bus.wb_reg_write != '0);
    assign bus.wb_regwrite = bus.wb_valid & w_head_rw & w_dest_ok;
    assign bus.wb_result   = bus.wb_memtoreg ? bus.wb_data_out : bus.wb_alu;

    assign bus.fwd_en   = bus.wb_regwrite;
    assign bus.fwd_addr = bus.wb_reg_write;
    assign bus.fwd_data = bus.wb_result;

endmodule
